// File: rtl/img_pkg.sv
// Shared frame-geometry defaults and scheduler types for the image tiling path.
package img_pkg;
  localparam int IMG_WIDTH_DEF  = 400;
  localparam int IMG_HEIGHT_DEF = 300;
  localparam int COORD_W_DEF    = 9;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_EN,
    S_PROCESS,
    S_ADVANCE,
    S_DONE
  } sched_state_t;

  typedef logic [1:0] win_sub_t;
endpackage

// File: rtl/tile_coord_counter.sv
// Raster tile-origin counter: origins step by 2 across a row, then wrap to the next row pair.
module tile_coord_counter import img_pkg::*; #(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int COORD_W    = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last
);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 4);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 4);

  assign last = (row == LAST_ROW) && (col == LAST_COL);

  // Stepping off the final tile returns to the origin so an idle frame reads (0,0).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col < LAST_COL) begin
        col <= col + COORD_W'(2);
      end else begin
        col <= '0;
        row <= last ? '0 : row + COORD_W'(2);
      end
    end
  end
endmodule

// File: rtl/tile_scheduler.sv
// Frame sequencer for the 3x3 image_buffer: fetch a 4x4 tile, load it, then walk its 4 windows.
module tile_scheduler import img_pkg::*; #(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int COORD_W    = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               fetch_ack,
  input  logic               calc_enable,
  input  logic               calc_done,
  output logic               fetch_req,
  output logic [COORD_W-1:0] fetch_row,
  output logic [COORD_W-1:0] fetch_col,
  output logic               load_enable,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic               busy,
  output logic               frame_done
);
  sched_state_t       state, state_nxt;
  win_sub_t           sub;
  logic               tile_clear, tile_step, tile_last, win_fire;
  logic [COORD_W-1:0] win_row_q, win_col_q;

  assign win_fire = (state == S_PROCESS) && calc_enable && calc_done;

  tile_coord_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .COORD_W   (COORD_W)
  ) u_tile (
    .clk  (clk),
    .rst  (rst),
    .clear(tile_clear),
    .step (tile_step),
    .row  (fetch_row),
    .col  (fetch_col),
    .last (tile_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start)       state_nxt = S_FETCH;
      S_FETCH:   if (fetch_ack)   state_nxt = S_LOAD;
      S_LOAD:                     state_nxt = S_WAIT_EN;
      S_WAIT_EN: if (calc_enable) state_nxt = S_PROCESS;
      S_PROCESS: if (win_fire && sub == 2'd3) state_nxt = S_ADVANCE;
      S_ADVANCE:                  state_nxt = tile_last ? S_DONE : S_FETCH;
      S_DONE:                     state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_req   = 1'b0;
    load_enable = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    tile_clear  = 1'b0;
    tile_step   = 1'b0;
    unique case (state)
      S_IDLE:    tile_clear = start;
      S_FETCH:   begin fetch_req = 1'b1; busy = 1'b1; end
      S_LOAD:    begin load_enable = 1'b1; busy = 1'b1; end
      S_WAIT_EN: busy = 1'b1;
      S_PROCESS: busy = 1'b1;
      S_ADVANCE: begin tile_step = 1'b1; busy = 1'b1; end
      S_DONE:    frame_done = 1'b1;
      default:   ;
    endcase
  end

  // Sub index is re-armed while waiting for the buffer so every tile starts at offset (0,0).
  always_ff @(posedge clk) begin
    if (rst)                     sub <= '0;
    else if (state == S_WAIT_EN) sub <= '0;
    else if (win_fire)           sub <= sub + 2'd1;
  end

  // Window coordinates are live in PROCESS and frozen at their last value elsewhere.
  assign win_row = (state == S_PROCESS) ? fetch_row + COORD_W'(sub[1]) : win_row_q;
  assign win_col = (state == S_PROCESS) ? fetch_col + COORD_W'(sub[0]) : win_col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      win_row_q <= win_row;
      win_col_q <= win_col;
    end
  end
endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler on a small 8x6 frame with randomized handshake timing.
module tb_tile_scheduler;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 4;
  localparam int NT = ((W - 2) / 2) * ((H - 2) / 2);

  logic          tb_clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, fetch_ack = 1'b0, calc_enable = 1'b0, calc_done = 1'b0;
  logic          fetch_req, load_enable, busy, frame_done;
  logic [CW-1:0] fetch_row, fetch_col, win_row, win_col;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_count = 0;
  int exp_r[$];
  int exp_c[$];

  logic [CW-1:0] obs_r, obs_c;
  logic [CW-1:0] obs_wr[4];
  logic [CW-1:0] obs_wc[4];
  bit            obs_load, obs_to;

  always #5 tb_clk = ~tb_clk;

  always @(negedge tb_clk) fd_count += int'(frame_done === 1'b1);

  tile_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .start      (start),
    .fetch_ack  (fetch_ack),
    .calc_enable(calc_enable),
    .calc_done  (calc_done),
    .fetch_req  (fetch_req),
    .fetch_row  (fetch_row),
    .fetch_col  (fetch_col),
    .load_enable(load_enable),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic tick;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; fetch_ack = 1'b0; calc_enable = 1'b0; calc_done = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Plays pixel memory and the conv engine for one tile; records what the DUT presented.
  task automatic drive_tile(input int ack_dly, input int en_dly, input int gap_max, input int n_done);
    int n = 0;
    obs_to = 1'b0;
    while (fetch_req !== 1'b1 && n < 50) begin tick; n++; end
    if (fetch_req !== 1'b1) begin obs_to = 1'b1; return; end
    obs_r = fetch_row;
    obs_c = fetch_col;
    repeat (ack_dly) tick;
    fetch_ack = 1'b1; tick; fetch_ack = 1'b0;
    obs_load = (load_enable === 1'b1);
    tick;
    obs_load = obs_load && (load_enable === 1'b0);
    repeat (en_dly) tick;
    calc_enable = 1'b1;
    tick;
    for (int k = 0; k < n_done; k++) begin
      repeat ($urandom_range(gap_max, 0)) tick;
      obs_wr[k] = win_row;
      obs_wc[k] = win_col;
      calc_done = 1'b1; tick; calc_done = 1'b0;
    end
    if (n_done == 4) calc_enable = 1'b0;
  endtask

  task automatic test_reset;
    logic [4+4*CW-1:0] v;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      tick;
      v = {fetch_req, load_enable, busy, frame_done, fetch_row, fetch_col, win_row, win_col};
      n_checks++;
      if (v !== '0) begin n_fail++; $display("FAIL reset_hold cyc=%0d outputs=%h expected 0", i, v); end
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      v = {fetch_req, load_enable, busy, frame_done, fetch_row, fetch_col, win_row, win_col};
      n_checks++;
      if (v !== '0) begin n_fail++; $display("FAIL reset_idle cyc=%0d outputs=%h expected 0", i, v); end
    end
  endtask

  task automatic test_single_tile;
    do_reset;
    do_start;
    n_checks++;
    if (fetch_req !== 1'b1 || busy !== 1'b1)
      begin n_fail++; $display("FAIL single_first_req req=%b busy=%b expected 1 1", fetch_req, busy); end
    drive_tile(2, 1, 0, 4);
    n_checks++;
    if (obs_to || obs_r !== 0 || obs_c !== 0)
      begin n_fail++; $display("FAIL single_origin to=%b got (%0d,%0d) expected (0,0)", obs_to, obs_r, obs_c); end
    n_checks++;
    if (!obs_load) begin n_fail++; $display("FAIL single_load load_enable not a 1-cycle pulse after ack"); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_wr[k] !== CW'(k / 2) || obs_wc[k] !== CW'(k % 2))
        begin n_fail++; $display("FAIL single_win k=%0d got (%0d,%0d) expected (%0d,%0d)", k, obs_wr[k], obs_wc[k], k / 2, k % 2); end
    end
    n_checks++;
    if (fetch_req !== 1'b0) begin n_fail++; $display("FAIL single_advance fetch_req=%b expected 0", fetch_req); end
    tick;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_row !== 0 || fetch_col !== CW'(2))
      begin n_fail++; $display("FAIL single_next req=%b (%0d,%0d) expected 1 (0,2)", fetch_req, fetch_row, fetch_col); end
  endtask

  task automatic test_full_frame;
    int fd0;
    do_reset;
    fd0 = fd_count;
    do_start;
    for (int t = 0; t < NT; t++) begin
      drive_tile($urandom_range(3, 0), $urandom_range(3, 0), 2, 4);
      n_checks++;
      if (obs_to) begin n_fail++; $display("FAIL frame_timeout tile=%0d no fetch_req", t); return; end
      n_checks++;
      if (obs_r !== CW'(exp_r[t]) || obs_c !== CW'(exp_c[t]) || !obs_load)
        begin n_fail++; $display("FAIL frame_tile t=%0d got (%0d,%0d) load=%b expected (%0d,%0d) load=1", t, obs_r, obs_c, obs_load, exp_r[t], exp_c[t]); end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_wr[k] !== CW'(exp_r[t] + k / 2) || obs_wc[k] !== CW'(exp_c[t] + k % 2))
          begin n_fail++; $display("FAIL frame_win t=%0d k=%0d got (%0d,%0d) expected (%0d,%0d)", t, k, obs_wr[k], obs_wc[k], exp_r[t] + k / 2, exp_c[t] + k % 2); end
      end
    end
    tick;
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL frame_done_cycle done=%b busy=%b expected 1 0", frame_done, busy); end
    repeat (5) tick;
    n_checks++;
    if (fd_count - fd0 !== 1) begin n_fail++; $display("FAIL frame_done_count got %0d expected 1", fd_count - fd0); end
  endtask

  task automatic test_spurious;
    do_reset;
    do_start;
    calc_enable = 1'b1; calc_done = 1'b1; tick; calc_done = 1'b0; calc_enable = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_row !== 0 || fetch_col !== 0 || load_enable !== 1'b0)
      begin n_fail++; $display("FAIL spur_fetch_done req=%b (%0d,%0d) load=%b expected 1 (0,0) 0", fetch_req, fetch_row, fetch_col, load_enable); end
    start = 1'b1; tick; start = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_row !== 0 || fetch_col !== 0)
      begin n_fail++; $display("FAIL spur_fetch_start req=%b (%0d,%0d) expected 1 (0,0)", fetch_req, fetch_row, fetch_col); end
    fetch_ack = 1'b1; tick; fetch_ack = 1'b0;
    n_checks++;
    if (load_enable !== 1'b1) begin n_fail++; $display("FAIL spur_load load_enable=%b expected 1", load_enable); end
    tick;
    calc_done = 1'b1; start = 1'b1; tick; calc_done = 1'b0; start = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b0 || load_enable !== 1'b0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL spur_wait req=%b load=%b busy=%b expected 0 0 1", fetch_req, load_enable, busy); end
    calc_enable = 1'b1; tick;
    n_checks++;
    if (win_row !== 0 || win_col !== 0) begin n_fail++; $display("FAIL spur_win0 got (%0d,%0d) expected (0,0)", win_row, win_col); end
    calc_done = 1'b1; tick; calc_done = 1'b0;
    fetch_ack = 1'b1; start = 1'b1; tick; fetch_ack = 1'b0; start = 1'b0;
    n_checks++;
    if (win_row !== 0 || win_col !== CW'(1) || fetch_req !== 1'b0 || load_enable !== 1'b0)
      begin n_fail++; $display("FAIL spur_process_ack got (%0d,%0d) req=%b load=%b expected (0,1) 0 0", win_row, win_col, fetch_req, load_enable); end
    calc_enable = 1'b0; calc_done = 1'b1; tick;
    n_checks++;
    if (win_row !== 0 || win_col !== CW'(1)) begin n_fail++; $display("FAIL spur_done_no_en got (%0d,%0d) expected (0,1)", win_row, win_col); end
    calc_enable = 1'b1; tick;
    n_checks++;
    if (win_row !== CW'(1) || win_col !== 0) begin n_fail++; $display("FAIL spur_win2 got (%0d,%0d) expected (1,0)", win_row, win_col); end
    tick;
    n_checks++;
    if (win_row !== CW'(1) || win_col !== CW'(1)) begin n_fail++; $display("FAIL spur_win3 got (%0d,%0d) expected (1,1)", win_row, win_col); end
    tick; calc_done = 1'b0; calc_enable = 1'b0;
    tick;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_row !== 0 || fetch_col !== CW'(2))
      begin n_fail++; $display("FAIL spur_next req=%b (%0d,%0d) expected 1 (0,2)", fetch_req, fetch_row, fetch_col); end
  endtask

  task automatic test_abort;
    int fd0;
    logic [4+4*CW-1:0] v;
    do_reset;
    fd0 = fd_count;
    do_start;
    for (int t = 0; t < 4; t++) drive_tile($urandom_range(2, 0), $urandom_range(2, 0), 1, 4);
    drive_tile(0, 0, 1, 2);
    n_checks++;
    if (obs_to || obs_r !== CW'(2) || obs_c !== CW'(2))
      begin n_fail++; $display("FAIL abort_tile to=%b got (%0d,%0d) expected (2,2)", obs_to, obs_r, obs_c); end
    n_checks++;
    if (win_row !== CW'(3) || win_col !== CW'(2)) begin n_fail++; $display("FAIL abort_sub2 got (%0d,%0d) expected (3,2)", win_row, win_col); end
    rst = 1'b1; tick; rst = 1'b0; calc_enable = 1'b0;
    v = {fetch_req, load_enable, busy, frame_done, fetch_row, fetch_col, win_row, win_col};
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL abort_outputs outputs=%h expected 0", v); end
    repeat (5) tick;
    n_checks++;
    if (fd_count !== fd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL abort_no_done frame_done pulses=%0d busy=%b expected 0 0", fd_count - fd0, busy); end
    do_start;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_row !== 0 || fetch_col !== 0)
      begin n_fail++; $display("FAIL abort_restart req=%b (%0d,%0d) expected 1 (0,0)", fetch_req, fetch_row, fetch_col); end
  endtask

  // With every handshake tied high each tile takes 8 cycles: FETCH, LOAD, WAIT_EN, 4x PROCESS, ADVANCE.
  task automatic test_zero_wait;
    int fd0, t, o, nwin;
    bit efr, eld, efd, ebusy;
    do_reset;
    fd0 = fd_count;
    nwin = 0;
    fetch_ack = 1'b1; calc_enable = 1'b1; calc_done = 1'b1;
    do_start;
    for (int cyc = 0; cyc < NT * 8 + 8; cyc++) begin
      t = cyc / 8;
      o = cyc % 8;
      efr   = (cyc < NT * 8) && (o == 0);
      eld   = (cyc < NT * 8) && (o == 1);
      efd   = (cyc == NT * 8);
      ebusy = (cyc < NT * 8);
      n_checks++;
      if (fetch_req !== efr || load_enable !== eld || frame_done !== efd || busy !== ebusy)
        begin n_fail++; $display("FAIL zw_ctrl cyc=%0d req/load/done/busy=%b%b%b%b expected %b%b%b%b", cyc, fetch_req, load_enable, frame_done, busy, efr, eld, efd, ebusy); end
      if (efr) begin
        n_checks++;
        if (fetch_row !== CW'(exp_r[t]) || fetch_col !== CW'(exp_c[t]))
          begin n_fail++; $display("FAIL zw_origin t=%0d got (%0d,%0d) expected (%0d,%0d)", t, fetch_row, fetch_col, exp_r[t], exp_c[t]); end
      end
      if (cyc < NT * 8 && o >= 3 && o <= 6) begin
        n_checks++;
        if (win_row !== CW'(exp_r[t] + (o - 3) / 2) || win_col !== CW'(exp_c[t] + (o - 3) % 2))
          begin n_fail++; $display("FAIL zw_win t=%0d k=%0d got (%0d,%0d) expected (%0d,%0d)", t, o - 3, win_row, win_col, exp_r[t] + (o - 3) / 2, exp_c[t] + (o - 3) % 2); end
        else nwin++;
      end
      tick;
    end
    fetch_ack = 1'b0; calc_enable = 1'b0; calc_done = 1'b0;
    n_checks++;
    if (nwin !== NT * 4 || fd_count - fd0 !== 1)
      begin n_fail++; $display("FAIL zw_totals windows=%0d done=%0d expected %0d 1", nwin, fd_count - fd0, NT * 4); end
  endtask

  initial begin
    for (int r = 0; r + 4 <= H; r += 2)
      for (int c = 0; c + 4 <= W; c += 2) begin
        exp_r.push_back(r);
        exp_c.push_back(c);
      end
    test_reset;
    test_single_tile;
    test_full_frame;
    test_spurious;
    test_abort;
    test_zero_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
